ifu: RTL and testbench

Instruction fetch unit: owns the fetch PC and drives the instruction address into the combinational `pmem` read port, which returns the instruction word in the same cycle. The unit captures each returned word with its PC into a 2-entry buffer and presents it to the decode stage over a valid/ready handshake. It also accepts PC redirects from execute and a halt request.

---
 rtl/ifu.sv | 64 ++++++
 tb/tb_ifu.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// ifu: fetch PC owner feeding a 2-entry {pc, instr} buffer to decode over valid/ready.
module ifu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] instr_addr_ifu_o,
  input  logic [DATA_WIDTH-1:0] instr_ifu_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  input  logic                  instr_ready_i,
  output logic                  halted_o
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] buf_pc [2];
  logic [DATA_WIDTH-1:0] buf_instr [2];
  logic                  head, tail;
  logic [1:0]            count;
  logic                  deq, redir, fire;
  assign instr_addr_ifu_o = fetch_pc;
  assign instr_valid_o    = count != 2'd0;
  assign instr_o          = buf_instr[head];
  assign pc_o             = buf_pc[head];
  assign halted_o         = state == HALT;
  assign deq   = instr_valid_o && instr_ready_i;
  assign redir = redirect_valid_i && state != IDLE;
  assign fire  = state == RUN && !halt_i && !redirect_valid_i && (count != 2'd2 || deq);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      buf_pc    <= '{default: '0};
      buf_instr <= '{default: '0};
    end else begin
      state <= state == IDLE ? RUN : (state == RUN && halt_i) ? HALT : state;
      if (redir) begin
        fetch_pc <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        head     <= 1'b0;
        tail     <= 1'b0;
        count    <= 2'd0;
      end else begin
        if (fire) begin
          buf_pc[tail]    <= fetch_pc;
          buf_instr[tail] <= instr_ifu_i;
          tail            <= ~tail;
          fetch_pc        <= fetch_pc + ADDR_WIDTH'(4);
        end
        if (deq) head <= ~head;
        count <= count + {1'b0, fire} - {1'b0, deq};
      end
    end
  end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: scoreboard bench for ifu with a memory whose word equals its address.
module tb_ifu;
  logic        clk, rst;
  logic [31:0] instr_addr_ifu_o, instr_ifu_i, redirect_pc_i, instr_o, pc_o;
  logic        redirect_valid_i, halt_i, instr_valid_o, instr_ready_i, halted_o;
  logic [31:0] exp_q [$];
  int          checks = 0, errors = 0;
  ifu dut (
    .clk(clk), .rst(rst), .instr_addr_ifu_o(instr_addr_ifu_o), .instr_ifu_i(instr_ifu_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .instr_ready_i(instr_ready_i), .halted_o(halted_o)
  );
  assign instr_ifu_i = instr_addr_ifu_o;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    logic [31:0] e;
    if (instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("pc", pc_o, e);
        chk("instr", instr_o, e);
      end
    end
    @(negedge clk);
  endtask
  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask
  task automatic do_reset();
    instr_ready_i = 1'b0;
    redirect_valid_i = 1'b0;
    halt_i = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask
  task automatic free_run();
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_addr", instr_addr_ifu_o, 32'h8000_0000);
    chk("rst_halted", 32'(halted_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    push_seq(32'h8000_0000, 8);
    instr_ready_i = 1'b1;
    cyc();
    chk("c2_valid", 32'(instr_valid_o), 32'd0);
    chk("c2_addr", instr_addr_ifu_o, 32'h8000_0000);
    cyc();
    chk("c3_valid", 32'(instr_valid_o), 32'd1);
    for (int i = 0; i < 8; i++) cyc();
    instr_ready_i = 1'b0;
    chk("free_sb", 32'(exp_q.size()), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    instr_ready_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    halt_i = 1'b0;
    @(negedge clk);
    do_reset();
    free_run();
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    chk("bp_head3", pc_o, 32'h8000_0000);
    for (int i = 0; i < 4; i++) cyc();
    chk("bp_addr", instr_addr_ifu_o, 32'h8000_0008);
    chk("bp_head7", pc_o, 32'h8000_0000);
    chk("bp_valid", 32'(instr_valid_o), 32'd1);
    push_seq(32'h8000_0000, 6);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    instr_ready_i = 1'b0;
    chk("bp_sb", 32'(exp_q.size()), 32'd0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    exp_q.push_back(32'h8000_0000);
    instr_ready_i = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h8000_0102;
    cyc();
    redirect_valid_i = 1'b0;
    chk("rd_valid", 32'(instr_valid_o), 32'd0);
    chk("rd_addr", instr_addr_ifu_o, 32'h8000_0100);
    push_seq(32'h8000_0100, 2);
    for (int i = 0; i < 3; i++) cyc();
    instr_ready_i = 1'b0;
    chk("rd_sb", 32'(exp_q.size()), 32'd0);
    do_reset();
    cyc();
    cyc();
    halt_i = 1'b1;
    cyc();
    halt_i = 1'b0;
    chk("h_halted", 32'(halted_o), 32'd1);
    chk("h_valid", 32'(instr_valid_o), 32'd1);
    chk("h_addr", instr_addr_ifu_o, 32'h8000_0004);
    exp_q.push_back(32'h8000_0000);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("h_drained", 32'(instr_valid_o), 32'd0);
    chk("h_frozen", instr_addr_ifu_o, 32'h8000_0004);
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h8000_0203;
    cyc();
    redirect_valid_i = 1'b0;
    chk("h_rd_addr", instr_addr_ifu_o, 32'h8000_0200);
    for (int i = 0; i < 3; i++) cyc();
    chk("h_rd_valid", 32'(instr_valid_o), 32'd0);
    chk("h_rd_addr2", instr_addr_ifu_o, 32'h8000_0200);
    chk("h_still", 32'(halted_o), 32'd1);
    instr_ready_i = 1'b0;
    chk("h_sb", 32'(exp_q.size()), 32'd0);
    do_reset();
    instr_ready_i = 1'b1;
    cyc();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    cyc();
    redirect_valid_i = 1'b0;
    chk("w_addr", instr_addr_ifu_o, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    push_seq(32'h0000_0000, 2);
    for (int i = 0; i < 4; i++) cyc();
    instr_ready_i = 1'b0;
    chk("w_sb", 32'(exp_q.size()), 32'd0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    chk("mr_full", instr_addr_ifu_o, 32'h8000_0008);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_halted", 32'(halted_o), 32'd0);
    free_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
